// File: rtl/ahbapb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ahbapb_pkg
// Description : Shared types and bus codes for the AHB-Lite to APB3 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbapb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    // States in which the AHB side samples a new address phase
    function automatic logic is_accept_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slot_mux.sv
`default_nettype none
// ============================================================================
// Module      : apb_slot_mux
// Description : Selects PRDATA/PREADY/PSLVERR of the addressed APB slot;
//               an index beyond NUM_SLOTS returns all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slot_mux
    import ahbapb_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int SEL_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic [SEL_W-1:0]            i_idx,
    input  logic [NUM_SLOTS*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLOTS-1:0]        i_pready,
    input  logic [NUM_SLOTS-1:0]        i_pslverr,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_ready,
    output logic                        o_err
);

    always_comb begin
        o_rdata = '0;
        o_ready = 1'b0;
        o_err   = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (i_idx == SEL_W'(k)) begin
                o_rdata = i_prdata[k*DATA_W +: DATA_W];
                o_ready = i_pready[k];
                o_err   = i_pslverr[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_apb_bridge_mslot.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_bridge_mslot
// Description : AHB-Lite slave to APB3 master bridge with NUM_SLOTS slots.
//               Optional macro APB_TIMEOUT_EN adds an ACCESS-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_apb_bridge_mslot
    import ahbapb_pkg::*;
#(
    parameter int NUM_SLOTS      = 16,
    parameter int SLOT_LSB       = 8,
    parameter int SEL_W          = 4,
    parameter int APB_ADDR_W     = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        HCLK,
    input  logic                        HRESETN,
    input  logic                        HSEL,
    input  logic [31:0]                 HADDR,
    input  logic                        HWRITE,
    input  logic [1:0]                  HTRANS,
    input  logic [2:0]                  HSIZE,
    input  logic [DATA_W-1:0]           HWDATA,
    input  logic                        HREADYIN,
    output logic                        HREADYOUT,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HRESP,
    output logic [NUM_SLOTS-1:0]        PSEL,
    output logic [APB_ADDR_W-1:0]       PADDR,
    output logic                        PWRITE,
    output logic                        PENABLE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic [NUM_SLOTS*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLOTS-1:0]        PREADY,
    input  logic [NUM_SLOTS-1:0]        PSLVERR
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SEL_W-1:0]        r_idx;
    logic [APB_ADDR_W-1:0]   r_addr;
    logic                    r_write;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_sel_ready;
    logic                    w_sel_err;
    logic                    w_timeout;
    logic [DATA_W-1:0]       w_sel_rdata;
    logic [NUM_SLOTS-1:0]    w_onehot;
    logic                    w_unused;

    assign w_accept = HSEL && HREADYIN
                   && ((HTRANS == c_HTRANS_NONSEQ) || (HTRANS == c_HTRANS_SEQ))
                   && is_accept_state(r_state);
    assign w_in_range = (int'(r_idx) < NUM_SLOTS);
    assign w_unused   = ^{HSIZE, HADDR};

    apb_slot_mux #(
        .NUM_SLOTS (NUM_SLOTS),
        .SEL_W     (SEL_W),
        .DATA_W    (DATA_W)
    ) u_slot_mux (
        .i_idx     (r_idx),
        .i_prdata  (PRDATA),
        .i_pready  (PREADY),
        .i_pslverr (PSLVERR),
        .o_rdata   (w_sel_rdata),
        .o_ready   (w_sel_ready),
        .o_err     (w_sel_err)
    );

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_onehot[k] = (r_idx == SEL_W'(k));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= HADDR[SLOT_LSB +: SEL_W];
            r_addr  <= HADDR[APB_ADDR_W-1:0];
            r_write <= HWRITE;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_TO_W_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int c_TO_W     = (c_TO_W_RAW < 8) ? 8 : ((c_TO_W_RAW > 16) ? 16 : c_TO_W_RAW);

    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !w_sel_ready) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    // A PREADY on the expiry cycle wins over the timeout
    assign w_timeout = (r_state == ST_ACCESS) && !w_sel_ready
                    && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_state_next = w_in_range ? ST_SETUP : ST_ERR1;
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_sel_ready) begin
                    w_state_next = w_sel_err ? ST_ERR1 : ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR1;
                end
            end
            ST_ERR1: begin
                w_state_next = ST_ERR2;
            end
            ST_DONE, ST_ERR2: begin
                w_state_next = w_accept ? ST_LATCH : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = c_HRESP_OKAY;
        case (r_state)
            ST_LATCH, ST_SETUP, ST_ACCESS: begin
                HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = c_HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP     = c_HRESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    // APB side registers; HRDATA only changes on a successful read
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            HRDATA  <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    if (r_write) PWDATA <= HWDATA;
                    if (w_in_range) begin
                        PSEL   <= w_onehot;
                        PADDR  <= r_addr;
                        PWRITE <= r_write;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (w_sel_ready || w_timeout) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                    end
                    if (w_sel_ready && !w_sel_err && !r_write) begin
                        HRDATA <= w_sel_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_apb_bridge_mslot.md
Name: ahb_apb_bridge_mslot

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge with NUM_SLOTS APB slave slots, per-slot PRDATA/PREADY/PSLVERR return muxing, APB wait states and PSLVERR-to-HRESP two-cycle ERROR.
- Sits behind the AHB decoder's HSEL line.
- Drives the APB peripheral segment (UART and other APB cores) in system and BFM testbenches.

Parameters:
NUM_SLOTS, 16, number of APB slots (1..16), one PSEL bit each
SLOT_LSB, 8, lowest HADDR bit of the slot index field
SEL_W, 4, slot index width; must satisfy 2**SEL_W >= NUM_SLOTS
APB_ADDR_W, 32, PADDR width; PADDR = HADDR[APB_ADDR_W-1:0]
DATA_W, 32, data width (32 only in this generation; parameter reserved)
TIMEOUT_CYCLES, 256, ACCESS-state limit, used only with APB_TIMEOUT_EN

Ports:
HCLK  in  1  single clock for the AHB and APB sides
HRESETN  in  1  asynchronous active-low reset
HSEL  in  1  bridge selected
HADDR  in  32  AHB address
HWRITE  in  1  write = 1
HTRANS  in  2  AHB transfer type
HSIZE  in  3  transfer size, accepted and not checked
HWDATA  in  DATA_W  write data, valid in the data phase
HREADYIN  in  1  bus-wide HREADY
HREADYOUT  out  1  bridge ready
HRDATA  out  DATA_W  read data, registered
HRESP  out  1  0 = OKAY, 1 = ERROR
PSEL  out  NUM_SLOTS  one-hot slot select
PADDR  out  APB_ADDR_W  APB address
PWRITE  out  1  APB write
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  APB write data
PRDATA  in  NUM_SLOTS*DATA_W  concatenated per-slot read data; slot k at [k*DATA_W +: DATA_W]
PREADY  in  NUM_SLOTS  per-slot ready
PSLVERR  in  NUM_SLOTS  per-slot error

Behaviour:
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, state = IDLE. Reset asserted mid-transfer aborts the transfer immediately. No APB completion follows reset.
- Accept condition: HSEL & HTRANS[1] & HREADYIN, sampled in IDLE, DONE or ERR2. On accept, HADDR, HWRITE and the slot index HADDR[SLOT_LSB +: SEL_W] are captured.
- IDLE and BUSY transfers (HTRANS[1] = 0) give a zero-wait OKAY and no APB activity.
- States and transitions:
  - IDLE: wait for accept.
  - LATCH: HREADYOUT = 0. Capture HWDATA into PWDATA (reads keep the old PWDATA). If index >= NUM_SLOTS, go to ERR1 with no APB cycle. Otherwise drive PSEL[index] = 1, PADDR and PWRITE at end of cycle, then go to SETUP.
  - SETUP: PSEL high, PENABLE = 0. Go to ACCESS.
  - ACCESS: PENABLE = 1, HREADYOUT = 0. Hold until PREADY[index] = 1. At that edge, deassert PSEL and PENABLE. If PSLVERR[index] = 1, go to ERR1. Otherwise register PRDATA[index] into HRDATA on reads and go to DONE.
  - DONE: HREADYOUT = 1, HRESP = 0. Go to LATCH on accept, else IDLE.
  - ERR1: HRESP = 1, HREADYOUT = 0. Go to ERR2.
  - ERR2: HRESP = 1, HREADYOUT = 1. Go to LATCH on accept, else IDLE.
- Latency with zero-wait APB: accept edge, then 3 cycles with HREADYOUT low (LATCH, SETUP, ACCESS), then HREADYOUT high in DONE. Each cycle PREADY is low adds one cycle.
- Back-to-back transfers: an accept in DONE or ERR2 enters LATCH directly. PSEL stays low for at least one cycle between APB transfers.
- Only the selected slot's PREADY and PSLVERR are observed. PREADY and PSLVERR from unselected slots are ignored.
- HRDATA holds its value across writes and errors.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on SETUP entry and increments each ACCESS cycle while PREADY[index] = 0. When it reaches TIMEOUT_CYCLES-1, PSEL and PENABLE drop and the state goes to ERR1. A PREADY arriving on the expiry cycle takes priority and completes normally.
- Undefined: there is no counter, and ACCESS waits indefinitely.

Decomposition:
- Package ahbapb_pkg holds:
  - state enum (IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2);
  - HTRANS codes (IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11);
  - HRESP codes (OKAY = 0, ERROR = 1).
- Sub-module apb_slot_mux: purely combinational selection of PRDATA, PREADY and PSLVERR by the registered slot index. The index is clamped, and out-of-range selects 0.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0304 (slot 3), PREADY tied 1: PSEL = 16'h0008, PADDR = 0x304, PWDATA = 0xDEADBEEF, PWRITE = 1. HREADYOUT is low for 3 cycles, then OKAY.
- Read from slot 5 with PREADY[5] low for 4 ACCESS cycles and PRDATA slot 5 = 0x1234_5678: HREADYOUT is low for 7 cycles, then HRDATA = 0x12345678 with HRESP = 0.
- Write to slot 2 with PSLVERR[2] = 1 at PREADY: ERR1 shows HRESP = 1 and HREADYOUT = 0. ERR2 shows HRESP = 1 and HREADYOUT = 1.
- NUM_SLOTS = 12, access to index 13: PSEL stays 0 throughout and a two-cycle ERROR is returned.
- Back-to-back NONSEQ transfers (write slot 0, then read slot 1), with HRESETN pulsed low during the second ACCESS: all outputs return to reset values asynchronously, HREADYOUT = 1 and PSEL = 0.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 8, PREADY stuck at 0: PENABLE stays high for 8 cycles, then a two-cycle ERROR. Without the macro the bench observes no timeout after 1000 cycles.
